// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-enable mask for an access of width funct3[1:0] at byte offset off.
    function automatic logic [3:0] be_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load alignment and sign/zero extension of a 32-bit read word.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then extend according to funct3.
    always_comb begin
        byte_sel = rdata[8*offset +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ext = {24'd0, byte_sel};
            F3_H:    ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ext = {16'd0, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// M-stage data-memory access: fault check, request/ready handshake,
// store lane replication and registered load extension.
module memory_stage
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  FaultM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    mem_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;
    logic [1:0]            off_q;
    logic [3:0]            be_q;
    logic                  we_q;
    logic [2:0]            f3_q;

    logic                  access, fault, capture, load_en;
    logic [DATA_WIDTH-1:0] wdata_d, ext;

    assign access = MemReadM | MemWriteM;

    // Fault decode: conflicting controls, reserved funct3, or misalignment.
    always_comb begin
        fault = 1'b0;
        if (MemReadM && MemWriteM)
            fault = 1'b1;
        if (Funct3M == 3'b011 || Funct3M == 3'b110 || Funct3M == 3'b111)
            fault = 1'b1;
        if (Funct3M[1:0] == 2'b01 && ALUResultM[0])
            fault = 1'b1;
        if (Funct3M[1:0] == 2'b10 && ALUResultM[1:0] != 2'b00)
            fault = 1'b1;
    end

    // Replicate narrow store data across every lane so the enables pick it.
    always_comb begin
        case (Funct3M[1:0])
            2'b00:   wdata_d = {4{WriteDataM[7:0]}};
            2'b01:   wdata_d = {2{WriteDataM[15:0]}};
            default: wdata_d = WriteDataM;
        endcase
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        StallM  = 1'b0;
        FaultM  = 1'b0;
        mem_req = 1'b0;
        capture = 1'b0;
        load_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (fault) begin
                        FaultM = 1'b1;
                    end else begin
                        StallM  = 1'b1;
                        capture = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                mem_req = 1'b1;
                StallM  = 1'b1;
                if (mem_ready) begin
                    load_en = ~we_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Capture the request fields when a legal access is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            off_q   <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
        end else if (capture) begin
            addr_q  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            wdata_q <= wdata_d;
            off_q   <= ALUResultM[1:0];
            be_q    <= be_mask(Funct3M, ALUResultM[1:0]);
            we_q    <= MemWriteM;
            f3_q    <= Funct3M;
        end
    end

    load_extend u_ext (
        .rdata  (mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .ext    (ext)
    );

    // Load result register; only a completing load updates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rdata_q <= '0;
        else if (load_en) rdata_q <= ext;
    end

    assign ReadDataM = rdata_q;
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table plus scoreboard of
// expected memory requests and load results.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM, mem_addr, mem_wdata, mem_rdata;
    logic        MemReadM, MemWriteM, StallM, FaultM, mem_req, mem_we, mem_ready;
    logic [2:0]  Funct3M;
    logic [3:0]  mem_be;

    memory_stage #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .FaultM     (FaultM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] rdata;
        int          wait_n;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
        logic [31:0] rd;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          pass_cnt = 0;
    int          total    = 0;
    logic [31:0] last_rd  = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] rdata, input int wait_n, input logic fault,
                                input logic [3:0] be, input logic [31:0] exp_wd,
                                input logic [31:0] exp_rd);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.rd = rd; v.wr = wr; v.f3 = f3;
        v.rdata = rdata; v.wait_n = wait_n; v.fault = fault; v.be = be;
        v.exp_wd = exp_wd; v.exp_rd = exp_rd;
        return v;
    endfunction

    // Drive one M-stage instruction and follow it to completion.
    task automatic access(input vec_t v);
        exp_t e;
        int   stalls, busy;
        bit   done;
        @(negedge clk);
        ALUResultM = v.addr; WriteDataM = v.wdata; MemReadM = v.rd; MemWriteM = v.wr;
        Funct3M = v.f3; mem_ready = 1'b0; mem_rdata = 32'h0;
        #1;
        if (v.fault) begin
            chk("fault_flag", {31'd0, FaultM}, 32'd1);
            chk("fault_stall", {31'd0, StallM}, 32'd0);
            chk("fault_req", {31'd0, mem_req}, 32'd0);
            @(negedge clk);
            MemReadM = 1'b0; MemWriteM = 1'b0;
            #1;
            chk("fault_after", {29'd0, FaultM, StallM, mem_req}, 32'd0);
            chk("fault_rd_hold", ReadDataM, last_rd);
            return;
        end
        chk("no_fault", {31'd0, FaultM}, 32'd0);
        e.addr = {v.addr[31:2], 2'b00};
        e.be   = v.be;
        e.wd   = v.exp_wd;
        e.we   = v.wr;
        if (v.rd) last_rd = v.exp_rd;
        e.rd   = last_rd;
        sb.push_back(e);
        stalls = StallM ? 1 : 0;
        busy   = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            #1;
            if (mem_req) begin
                chk("req_addr", mem_addr, sb[0].addr);
                chk("req_be", {28'd0, mem_be}, {28'd0, sb[0].be});
                chk("req_we", {31'd0, mem_we}, {31'd0, sb[0].we});
                if (sb[0].we) chk("req_wdata", mem_wdata, sb[0].wd);
                if (StallM) stalls++;
                mem_ready = (busy == v.wait_n);
                mem_rdata = mem_ready ? v.rdata : 32'h5A5A_5A5A;
                busy++;
            end else begin
                done = 1'b1;
                chk("done_rdata", ReadDataM, sb[0].rd);
                chk("done_stall", {31'd0, StallM}, 32'd0);
                chk("stall_cycles", stalls, 2 + v.wait_n);
                void'(sb.pop_front());
                MemReadM = 1'b0; MemWriteM = 1'b0;
                // A stray ready outside BUSY must not disturb anything.
                mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
            end
        end
        if (!done) begin
            chk("timeout", 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ALUResultM = 0; WriteDataM = 0; MemReadM = 0; MemWriteM = 0; Funct3M = 0;
        mem_ready = 0; mem_rdata = 0;

        // addr, wdata, rd, wr, f3, rdata, wait, fault, be, exp_wdata, exp_rdata
        vecs.push_back(mk(32'h100, 32'h0,        1, 0, 3'b010, 32'hDEADBEEF, 0, 0, 4'b1111, 32'h0,        32'hDEADBEEF));
        vecs.push_back(mk(32'h103, 32'h0,        1, 0, 3'b000, 32'h80112233, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80));
        vecs.push_back(mk(32'h103, 32'h0,        1, 0, 3'b100, 32'h80112233, 0, 0, 4'b1000, 32'h0,        32'h00000080));
        vecs.push_back(mk(32'h202, 32'h1234ABCD, 0, 1, 3'b001, 32'h0,        0, 0, 4'b1100, 32'hABCDABCD, 32'h0));
        vecs.push_back(mk(32'h400, 32'h0,        1, 0, 3'b010, 32'h0BADF00D, 5, 0, 4'b1111, 32'h0,        32'h0BADF00D));
        vecs.push_back(mk(32'h301, 32'h0,        1, 0, 3'b001, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(32'h302, 32'h0,        1, 0, 3'b001, 32'h80017FFF, 1, 0, 4'b1100, 32'h0,        32'hFFFF8001));
        vecs.push_back(mk(32'h300, 32'h0,        1, 0, 3'b101, 32'h8001F0F0, 2, 0, 4'b0011, 32'h0,        32'h0000F0F0));
        vecs.push_back(mk(32'h105, 32'h000000AB, 0, 1, 3'b000, 32'h0,        0, 0, 4'b0010, 32'hABABABAB, 32'h0));
        vecs.push_back(mk(32'h10C, 32'h11223344, 0, 1, 3'b010, 32'h0,        3, 0, 4'b1111, 32'h11223344, 32'h0));
        vecs.push_back(mk(32'h102, 32'h0,        1, 0, 3'b010, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(32'h100, 32'h0,        1, 0, 3'b011, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(32'h100, 32'h0,        1, 1, 3'b010, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(32'h208, 32'hCAFE0000, 0, 1, 3'b110, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(32'h101, 32'h0,        1, 0, 3'b000, 32'h00007F00, 0, 0, 4'b0010, 32'h0,        32'h0000007F));

        // Reset values.
        #1;
        chk("rst_rdata", ReadDataM, 32'h0);
        chk("rst_ctl", {26'd0, StallM, FaultM, mem_req, mem_we, 2'b00}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be", {28'd0, mem_be}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) access(vecs[i]);

        // Idle cycle with ready asserted: load result must hold.
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        #1;
        chk("idle_ready_ignored", ReadDataM, last_rd);
        chk("idle_no_req", {31'd0, mem_req}, 32'd0);
        mem_ready = 1'b0;

        // Reset asserted while a request is outstanding.
        @(negedge clk);
        ALUResultM = 32'h500; MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010;
        @(negedge clk);
        #1;
        chk("busy_before_rst", {31'd0, mem_req}, 32'd1);
        MemReadM = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, StallM}, 32'd0);
        chk("rst_mid_rdata", ReadDataM, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        last_rd = 32'h0;
        @(negedge clk);
        #1;
        chk("post_rst_idle", {31'd0, mem_req}, 32'd0);
        access(mk(32'h504, 32'h0, 1, 0, 3'b010, 32'h600DF00D, 1, 0, 4'b1111, 32'h0, 32'h600DF00D));

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
